// File: rtl/cluster_pkg.sv
// Shared definitions for the 768-pad cluster encoder/unpacker pair:
// map geometry, reserved "no cluster" addresses and the cluster word layout.
package cluster_pkg;

  localparam int MXPADS     = 768;
  localparam int MXADRBITS  = 11;
  localparam int MXCNTBITS  = 3;
  localparam int MXCLSTBITS = 8;

  localparam logic [MXADRBITS-1:0] ADR_NONE = 11'h7FE;
  localparam logic [MXADRBITS-1:0] ADR_NULL = 11'h7FF;
  localparam logic [MXADRBITS-1:0] LAST_ADR = MXADRBITS'(MXPADS - 1);

  typedef struct packed {
    logic [MXADRBITS-1:0] adr;
    logic [MXCNTBITS-1:0] cnt;
  } cluster_t;

  // The encoder scans pads in pairs; key k covers pads 2k and 2k+1.
  localparam int MXKEYS = MXPADS / 2;

  function automatic logic [MXADRBITS-2:0] pad_pair_key(input logic [MXADRBITS-1:0] a);
    return a[MXADRBITS-1:1];
  endfunction

endpackage

// File: rtl/cluster_unpacker768_span_mask.sv
// Combinational pad mask for one cluster: pads adr..adr+cnt, clipped at the
// last pad, with a flag when the span ran past the end of the map.
module cluster_span_mask
  import cluster_pkg::*;
(
  input  logic [MXADRBITS-1:0] adr,
  input  logic [MXCNTBITS-1:0] cnt,
  output logic [MXPADS-1:0]    mask,
  output logic                 clip
);

  localparam logic [MXADRBITS:0] LAST_PAD = (MXADRBITS + 1)'(MXPADS - 1);

  logic [MXADRBITS:0] span_start;
  logic [MXADRBITS:0] span_end;

  always_comb begin
    span_start = {1'b0, adr};
    // One extra bit so adr+cnt near the top of the address range cannot wrap.
    span_end   = span_start + {{(MXADRBITS + 1 - MXCNTBITS){1'b0}}, cnt};
    clip       = (span_start <= LAST_PAD) && (span_end > LAST_PAD);
    mask       = '0;
    for (int i = 0; i < MXPADS; i++) begin
      mask[i] = (span_start <= (MXADRBITS + 1)'(i)) && ((MXADRBITS + 1)'(i) <= span_end);
    end
  end

endmodule

// File: rtl/cluster_unpacker768.sv
// Rebuilds the per-pad hit and count maps of one frame from its stream of
// encoded cluster words and publishes them as a registered snapshot.
module cluster_unpacker768
  import cluster_pkg::*;
(
  input  logic                        clock,
  input  logic                        global_reset,
  input  logic                        frame_start,
  input  logic                        frame_end,
  input  logic                        cluster_valid,
  input  logic [MXADRBITS-1:0]        adr,
  input  logic [MXCNTBITS-1:0]        cnt,
  output logic [MXPADS-1:0]           vpfs_out,
  output logic [MXPADS*MXCNTBITS-1:0] cnts_out,
  output logic                        frame_valid,
  output logic [MXCLSTBITS-1:0]       n_clusters,
  output logic [MXCLSTBITS-1:0]       n_invalid,
  output logic                        overflow
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACTIVE  = 2'd1;
  localparam logic [1:0] ST_PUBLISH = 2'd2;
  localparam logic [MXCLSTBITS-1:0] CNT_ONE = MXCLSTBITS'(1);

  logic [1:0]                    state_q, state_d;
  logic [MXPADS-1:0]             vpfs_acc_q, vpfs_acc_d;
  logic [MXPADS*MXCNTBITS-1:0]   cnts_acc_q, cnts_acc_d;
  logic [MXCLSTBITS-1:0]         ncl_acc_q, ncl_acc_d;
  logic [MXCLSTBITS-1:0]         ninv_acc_q, ninv_acc_d;
  logic [MXPADS-1:0]             vpfs_out_q, vpfs_out_d;
  logic [MXPADS*MXCNTBITS-1:0]   cnts_out_q, cnts_out_d;
  logic [MXCLSTBITS-1:0]         ncl_out_q, ncl_out_d;
  logic [MXCLSTBITS-1:0]         ninv_out_q, ninv_out_d;
  logic                          frame_valid_q, frame_valid_d;
  logic                          overflow_q, overflow_d;

  cluster_t          cl;
  logic [MXPADS-1:0] span_mask;
  logic              span_clip;
  logic              accept;
  logic              pad_ok;
  logic              is_null;

  assign cl = {adr, cnt};

  cluster_span_mask u_span (
    .adr  (cl.adr),
    .cnt  (cl.cnt),
    .mask (span_mask),
    .clip (span_clip)
  );

  always_comb begin
    state_d       = state_q;
    vpfs_acc_d    = vpfs_acc_q;
    cnts_acc_d    = cnts_acc_q;
    ncl_acc_d     = ncl_acc_q;
    ninv_acc_d    = ninv_acc_q;
    vpfs_out_d    = vpfs_out_q;
    cnts_out_d    = cnts_out_q;
    ncl_out_d     = ncl_out_q;
    ninv_out_d    = ninv_out_q;
    frame_valid_d = 1'b0;
    overflow_d    = overflow_q;

    // A frame_start cycle opens a fresh frame, and its cluster belongs to it.
    accept  = cluster_valid && ((state_q == ST_ACTIVE) || frame_start);
    pad_ok  = (cl.adr <= LAST_ADR);
    is_null = (cl.adr == ADR_NONE) || (cl.adr == ADR_NULL);

    if (frame_start) begin
      vpfs_acc_d = '0;
      cnts_acc_d = '0;
      ncl_acc_d  = '0;
      ninv_acc_d = '0;
    end

    if (accept) begin
      if (pad_ok) begin
        vpfs_acc_d = vpfs_acc_d | span_mask;
        cnts_acc_d[cl.adr*MXCNTBITS +: MXCNTBITS] = cl.cnt;
        if (ncl_acc_d != '1) ncl_acc_d = ncl_acc_d + CNT_ONE;
        if (span_clip) overflow_d = 1'b1;
      end else if (!is_null) begin
        if (ninv_acc_d != '1) ninv_acc_d = ninv_acc_d + CNT_ONE;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_start) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // Snapshot is taken from the next accumulator so a cluster sharing
        // the frame_end cycle lands in the closing frame.
        if (!frame_start && frame_end) begin
          state_d       = ST_PUBLISH;
          vpfs_out_d    = vpfs_acc_d;
          cnts_out_d    = cnts_acc_d;
          ncl_out_d     = ncl_acc_d;
          ninv_out_d    = ninv_acc_d;
          frame_valid_d = 1'b1;
        end
      end
      ST_PUBLISH: begin
        state_d = frame_start ? ST_ACTIVE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      state_q       <= ST_IDLE;
      vpfs_acc_q    <= '0;
      cnts_acc_q    <= '0;
      ncl_acc_q     <= '0;
      ninv_acc_q    <= '0;
      vpfs_out_q    <= '0;
      cnts_out_q    <= '0;
      ncl_out_q     <= '0;
      ninv_out_q    <= '0;
      frame_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      vpfs_acc_q    <= vpfs_acc_d;
      cnts_acc_q    <= cnts_acc_d;
      ncl_acc_q     <= ncl_acc_d;
      ninv_acc_q    <= ninv_acc_d;
      vpfs_out_q    <= vpfs_out_d;
      cnts_out_q    <= cnts_out_d;
      ncl_out_q     <= ncl_out_d;
      ninv_out_q    <= ninv_out_d;
      frame_valid_q <= frame_valid_d;
      overflow_q    <= overflow_d;
    end
  end

  assign vpfs_out    = vpfs_out_q;
  assign cnts_out    = cnts_out_q;
  assign n_clusters  = ncl_out_q;
  assign n_invalid   = ninv_out_q;
  assign frame_valid = frame_valid_q;
  assign overflow    = overflow_q;

endmodule
